// File: rtl/cpu_pipe4.sv
// cpu_pipe4: 4-stage IF/ID/EX/MEM-WB pipelined core.
// EX forwarding, regfile write bypass, 1-cycle load-use stall, BEQ, HALT.
module cpu_pipe4 #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            halted
);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd2;
    localparam logic [5:0] OP_SW   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_HALT = 6'd63;
    localparam logic [5:0] NR      = 6'(NREGS);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     ir;
    } if_id_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [5:0]      op;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      dst;
        logic            wr;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [5:0]      op;
        logic [4:0]      dst;
        logic            wr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sd;
    } ex_mw_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] regs [NREGS];
    if_id_t          ifid;
    id_ex_t          idex;
    ex_mw_t          mw;
    logic            halt_pend;
    logic            halted_q;

    logic [5:0]      id_op;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_imm;
    logic            id_reads_rt;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;
    id_ex_t          id_next;

    logic            fwd_a;
    logic            fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu;
    logic            taken;
    logic [XLEN-1:0] target;
    ex_mw_t          ex_next;

    logic            load_use;
    logic            halt_in_id;
    logic            freeze;

    assign id_op  = ifid.ir[31:26];
    assign id_rs  = ifid.ir[25:21];
    assign id_rt  = ifid.ir[20:16];
    assign id_rd  = ifid.ir[15:11];
    assign id_imm = {{(XLEN-16){ifid.ir[15]}}, ifid.ir[15:0]};

    assign id_reads_rt = (id_op == OP_ADD) || (id_op == OP_SUB) ||
                         (id_op == OP_SW)  || (id_op == OP_BEQ);

    // Writeback side, also feeds the ID bypass
    assign retire_valid = mw.valid;
    assign retire_pc    = mw.pc;
    assign wb_en        = mw.valid && mw.wr;
    assign wb_addr      = mw.dst;
    assign wb_data      = (mw.op == OP_LW) ? dmem_rdata : mw.alu;
    assign dmem_addr    = mw.alu;
    assign dmem_wdata   = mw.sd;
    assign dmem_we      = mw.valid && (mw.op == OP_SW);
    assign halted       = halted_q;
    assign imem_addr    = pc;

    always_comb begin
        rd_a = '0;
        if (id_rs != 5'd0 && {1'b0, id_rs} < NR) begin
            rd_a = (wb_en && wb_addr == id_rs) ? wb_data : regs[id_rs];
        end
    end

    always_comb begin
        rd_b = '0;
        if (id_rt != 5'd0 && {1'b0, id_rt} < NR) begin
            rd_b = (wb_en && wb_addr == id_rt) ? wb_data : regs[id_rt];
        end
    end

    always_comb begin
        id_next       = '0;
        id_next.valid = ifid.valid;
        id_next.pc    = ifid.pc;
        id_next.op    = id_op;
        id_next.rs    = id_rs;
        id_next.rt    = id_rt;
        id_next.a     = rd_a;
        id_next.b     = rd_b;
        id_next.imm   = id_imm;
        unique case (1'b1)
            id_op == OP_ADD,
            id_op == OP_SUB:  id_next.dst = id_rd;
            id_op == OP_LW,
            id_op == OP_ADDI: id_next.dst = id_rt;
            default:          id_next.dst = 5'd0;
        endcase
        id_next.wr = (id_next.dst != 5'd0) && ({1'b0, id_next.dst} < NR);
    end

    // Only non-load results are available in time for EX
    assign fwd_a = mw.valid && mw.wr && (mw.op != OP_LW) && (mw.dst == idex.rs);
    assign fwd_b = mw.valid && mw.wr && (mw.op != OP_LW) && (mw.dst == idex.rt);
    assign op_a  = fwd_a ? mw.alu : idex.a;
    assign op_b  = fwd_b ? mw.alu : idex.b;

    always_comb begin
        alu = '0;
        unique case (1'b1)
            idex.op == OP_ADD:  alu = op_a + op_b;
            idex.op == OP_SUB:  alu = op_a - op_b;
            idex.op == OP_LW,
            idex.op == OP_SW,
            idex.op == OP_ADDI: alu = op_a + idex.imm;
            default:            alu = '0;
        endcase
    end

    assign taken  = idex.valid && (idex.op == OP_BEQ) && (op_a == op_b);
    assign target = idex.pc + XLEN'(4) + {idex.imm[XLEN-3:0], 2'b00};

    always_comb begin
        ex_next       = '0;
        ex_next.valid = idex.valid;
        ex_next.pc    = idex.pc;
        ex_next.op    = idex.op;
        ex_next.dst   = idex.dst;
        ex_next.wr    = idex.wr;
        ex_next.alu   = alu;
        ex_next.sd    = op_b;
    end

    assign load_use = idex.valid && (idex.op == OP_LW) && idex.wr &&
                      ifid.valid &&
                      ((idex.dst == id_rs) ||
                       (id_reads_rt && idex.dst == id_rt));

    assign halt_in_id = ifid.valid && (id_op == OP_HALT);
    assign freeze     = halt_in_id || halt_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            ifid      <= '0;
            idex      <= '0;
            mw        <= '0;
            halt_pend <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
            halted_q  <= halted_q || (mw.valid && mw.op == OP_HALT);
            halt_pend <= halt_pend || (halt_in_id && !taken);
            mw        <= idex.valid ? ex_next : '0;
            if (taken) begin
                pc   <= target;
                ifid <= '0;
                idex <= '0;
            end else if (load_use) begin
                idex <= '0;
            end else begin
                idex <= ifid.valid ? id_next : '0;
                if (freeze) begin
                    ifid <= '0;
                end else begin
                    ifid <= '{valid: 1'b1, pc: pc, ir: imem_rdata};
                    pc   <= pc + XLEN'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_pipe4.sv
// Bench for cpu_pipe4: directed program, retire scoreboard,
// timing of stall/branch bubbles, HALT and restart after reset.
module tb_cpu_pipe4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;

    cpu_pipe4 #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .halted(halted)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_we === 1'b1) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] daddr;
        logic [31:0] ddata;
    } exp_t;

    exp_t q[$];
    int   rc[int];
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int op, input int rd,
                                          input int rs, input int rt);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rt,
                                          input int rs, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic exp_w(input int pc, input int a, input int d);
        q.push_back('{pc, 1'b1, a[4:0], d, 1'b0, 32'h0, 32'h0});
    endtask

    task automatic exp_n(input int pc);
        q.push_back('{pc, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0});
    endtask

    task automatic exp_s(input int pc, input int a, input int d);
        q.push_back('{pc, 1'b0, 5'd0, 32'h0, 1'b1, a, d});
    endtask

    // Retire monitor: pops the scoreboard at each retirement
    always @(negedge clk) begin
        if (reset === 1'b0 && retire_valid === 1'b1) begin
            rc[retire_pc] = cyc;
            ncmp++;
            assert (q.size() > 0) else begin
                nfail++;
                $error("FAIL unexpected_retire: observed pc %0h expected none",
                       retire_pc);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("retire_pc", retire_pc, e.pc);
                chk("wb_en", 32'(wb_en), 32'(e.wen));
                if (e.wen) begin
                    chk("wb_addr", 32'(wb_addr), 32'(e.waddr));
                    chk("wb_data", wb_data, e.wdata);
                end
                chk("dmem_we", 32'(dmem_we), 32'(e.we));
                if (e.we) begin
                    chk("dmem_addr", dmem_addr, e.daddr);
                    chk("dmem_wdata", dmem_wdata, e.ddata);
                end
            end
        end
    end

    task automatic push_expected();
        exp_w(0, 1, 5);
        exp_w(4, 2, 10);
        exp_w(8, 3, 5);
        exp_w(12, 8, 32'h1234);
        exp_s(16, 8, 32'h1234);
        exp_w(20, 4, 32'h1234);
        exp_w(24, 5, 32'h2468);
        exp_n(28);
        exp_w(40, 1, 7);
        exp_s(44, 4, 7);
        exp_w(48, 6, 7);
        exp_n(52);
        exp_w(56, 7, 0);
        exp_n(60);
        exp_n(64);
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_sb_empty"}, q.size(), 0);
        chk({tag, "_fwd1"}, rc[4] - rc[0], 1);
        chk({tag, "_fwd2"}, rc[8] - rc[4], 1);
        chk({tag, "_lu_bubble"}, rc[24] - rc[20], 2);
        chk({tag, "_br_bubbles"}, rc[40] - rc[28], 3);
        chk({tag, "_sq32"}, 32'(rc.exists(32)), 0);
        chk({tag, "_sq36"}, 32'(rc.exists(36)), 0);
        chk({tag, "_m8"}, dmem[2], 32'h1234);
        chk({tag, "_m4"}, dmem[1], 7);
        repeat (10) @(negedge clk);
        chk({tag, "_halt_sticky"}, 32'(halted), 32'd1);
        chk({tag, "_pc_frozen"}, imem_addr, 68);
        chk({tag, "_post_halt"}, 32'(rc.exists(68)), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        imem[0]  = itype(4, 1, 0, 5);
        imem[1]  = rtype(0, 2, 1, 1);
        imem[2]  = rtype(1, 3, 2, 1);
        imem[3]  = itype(4, 8, 0, 32'h1234);
        imem[4]  = itype(3, 8, 0, 8);
        imem[5]  = itype(2, 4, 0, 8);
        imem[6]  = rtype(0, 5, 4, 4);
        imem[7]  = itype(5, 0, 0, 2);
        imem[8]  = itype(4, 9, 0, 1);
        imem[9]  = itype(4, 9, 0, 2);
        imem[10] = itype(4, 1, 0, 7);
        imem[11] = itype(3, 1, 0, 4);
        imem[12] = itype(2, 6, 0, 4);
        imem[13] = itype(4, 0, 0, 9);
        imem[14] = rtype(0, 7, 0, 0);
        imem[15] = {6'd10, 26'd0};
        imem[16] = {6'd63, 26'd0};
        imem[17] = itype(4, 11, 0, 3);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_retire", 32'(retire_valid), 0);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", imem_addr, 0);

        push_expected();
        reset = 1'b0;
        run_to_halt("run1");

        reset = 1'b1;
        @(negedge clk);
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_pc", imem_addr, 0);
        chk("rst2_retire", 32'(retire_valid), 0);
        rc.delete();
        push_expected();
        reset = 1'b0;
        run_to_halt("run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
